// File: rtl/gemm_output_collector.sv
// ============================================================================
// Module   : gemm_output_collector
// Brief    : Buffers GEMM output rows in a small FIFO and re-presents them
//            downstream with row index / last tags, job tracking and stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

package GEMM_pkg;
   typedef enum logic [1:0] {
      CMD_NONE          = 2'd0,
      CMD_WRITE_WEIGHTS = 2'd1,
      CMD_STREAM        = 2'd2
   } command_t;
endpackage

module gemm_output_collector
   import GEMM_pkg::*;
#(
   parameter int SA_SIZE                = 2,
   parameter int WEIGHT_ACTIVATION_SIZE = 8,
   parameter int DEPTH                  = 4,
   parameter int MAX_ROWS               = 16
) (
   input  logic                                             clk,
   input  logic                                             resetn,
   input  logic                                             start,
   input  logic [$clog2(MAX_ROWS+1)-1:0]                    num_rows,
   input  command_t                                         cmd,
   input  logic                                             output_valid,
   input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]   activation_outputs,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]   out_data,
   output logic [((MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1)-1:0] out_row_idx,
   output logic                                             out_last,
   output logic                                             stall_req,
   output logic                                             busy,
   output logic                                             done,
   output logic                                             overflow
);

   localparam int NW = $clog2(MAX_ROWS+1);
   localparam int RW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] STALL_LEVEL = PW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t              state;
   logic [NW-1:0]       rows_target;
   logic [NW-1:0]       captured;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;

   logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0] mem_data [DEPTH];
   logic [RW-1:0]       mem_idx  [DEPTH];
   logic                mem_last [DEPTH];

   logic                fifo_empty;
   logic                fifo_full;
   logic [PW-1:0]       fifo_count;
   logic                capture;
   logic                pop;
   logic                push;
   logic                drop;
   logic                is_last_row;

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fifo_count  = wr_ptr - rd_ptr;

   assign capture     = (state == COLLECT) && output_valid && (cmd == CMD_STREAM);
   assign pop         = out_valid && out_ready;
   // A full FIFO can still take a row when the head leaves in the same cycle.
   assign push        = capture && (!fifo_full || pop);
   assign drop        = capture && fifo_full && !pop;
   assign is_last_row = (captured == (rows_target - NW'(1)));

   assign busy        = (state == COLLECT) || (state == DRAIN);
   assign done        = (state == DONE);
   assign stall_req   = busy && (fifo_count >= STALL_LEVEL);

   // Head outputs are gated so an empty FIFO always presents zeros.
   assign out_valid   = !fifo_empty;
   assign out_data    = out_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
   assign out_row_idx = out_valid ? mem_idx[rd_ptr[AW-1:0]]  : '0;
   assign out_last    = out_valid ? mem_last[rd_ptr[AW-1:0]] : 1'b0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr[AW-1:0]] <= activation_outputs;
         mem_idx[wr_ptr[AW-1:0]]  <= captured[RW-1:0];
         mem_last[wr_ptr[AW-1:0]] <= is_last_row;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         rows_target <= '0;
         captured    <= '0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (num_rows != '0) begin
                     rows_target <= num_rows;
                     captured    <= '0;
                     overflow    <= 1'b0;
                     state       <= COLLECT;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            COLLECT: begin
               if (capture) begin
                  captured <= captured + NW'(1);
                  if (drop) overflow <= 1'b1;
                  if (is_last_row) state <= DRAIN;
               end
            end
            DRAIN: begin
               // Exit on the pop that empties the FIFO; the last entry may
               // not be tagged last if the final row was dropped.
               if (fifo_empty || (pop && fifo_count == PW'(1))) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gemm_output_collector.sv
// ============================================================================
// Module   : tb_gemm_output_collector
// Brief    : Directed self-checking bench for gemm_output_collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gemm_output_collector;
   import GEMM_pkg::*;

   logic             clk;
   logic             resetn;
   logic             start;
   logic [4:0]       num_rows;
   command_t         cmd;
   logic             output_valid;
   logic [1:0][7:0]  activation_outputs;
   logic             out_valid;
   logic             out_ready;
   logic [1:0][7:0]  out_data;
   logic [3:0]       out_row_idx;
   logic             out_last;
   logic             stall_req;
   logic             busy;
   logic             done;
   logic             overflow;

   int vectors;
   int miscompares;

   gemm_output_collector #(
      .SA_SIZE(2), .WEIGHT_ACTIVATION_SIZE(8), .DEPTH(4), .MAX_ROWS(16)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .num_rows(num_rows),
      .cmd(cmd), .output_valid(output_valid),
      .activation_outputs(activation_outputs),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row_idx(out_row_idx), .out_last(out_last), .stall_req(stall_req),
      .busy(busy), .done(done), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0][7:0] mk(input logic [7:0] a, input logic [7:0] b);
      logic [1:0][7:0] r;
      r[0] = a;
      r[1] = b;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " out_valid"}, 32'(out_valid), 0);
      check({tag, " out_data"},  32'(out_data), 0);
      check({tag, " out_row_idx"}, 32'(out_row_idx), 0);
      check({tag, " out_last"},  32'(out_last), 0);
      check({tag, " stall_req"}, 32'(stall_req), 0);
      check({tag, " busy"},      32'(busy), 0);
      check({tag, " done"},      32'(done), 0);
      check({tag, " overflow"},  32'(overflow), 0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      resetn = 1'b0;
      start = 1'b0;
      num_rows = '0;
      cmd = CMD_NONE;
      output_valid = 1'b0;
      activation_outputs = '0;
      out_ready = 1'b0;
      #3;
      check_all_zero("reset");
      tick(); tick();
      resetn = 1'b1;
      tick();

      // Basic job: two rows, consumer always ready
      start = 1'b1; num_rows = 5'd2; out_ready = 1'b1;
      tick();
      start = 1'b0;
      check("basic busy", 32'(busy), 1);
      output_valid = 1'b1; cmd = CMD_STREAM; activation_outputs = mk(8'd3, 8'd2);
      tick();
      check("basic r0 valid", 32'(out_valid), 1);
      check("basic r0 data", 32'(out_data), 32'h0203);
      check("basic r0 idx", 32'(out_row_idx), 0);
      check("basic r0 last", 32'(out_last), 0);
      activation_outputs = mk(8'd5, 8'd6);
      tick();
      output_valid = 1'b0;
      check("basic r1 data", 32'(out_data), 32'h0605);
      check("basic r1 idx", 32'(out_row_idx), 1);
      check("basic r1 last", 32'(out_last), 1);
      tick();
      check("basic done", 32'(done), 1);
      check("basic busy in done", 32'(busy), 0);
      check("basic empty", 32'(out_valid), 0);
      check("basic overflow", 32'(overflow), 0);
      tick();
      check("basic done one cycle", 32'(done), 0);

      // Backpressure: four rows held with consumer stalled
      out_ready = 1'b0;
      start = 1'b1; num_rows = 5'd4;
      tick();
      start = 1'b0;
      output_valid = 1'b1; cmd = CMD_STREAM;
      for (int i = 0; i < 4; i++) begin
         activation_outputs = mk(8'(8'h10 + i), 8'(8'h20 + i));
         tick();
         check("bp stall", 32'(stall_req), (i >= 2) ? 1 : 0);
         check("bp head stable", 32'(out_data), 32'h2010);
      end
      output_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("bp drain data", 32'(out_data), 32'({8'(8'h20 + i), 8'(8'h10 + i)}));
         check("bp drain idx", 32'(out_row_idx), 32'(i));
         check("bp drain last", 32'(out_last), (i == 3) ? 1 : 0);
         tick();
      end
      check("bp done", 32'(done), 1);
      tick();

      // Overflow: six rows into a four-entry FIFO
      out_ready = 1'b0;
      start = 1'b1; num_rows = 5'd6;
      tick();
      start = 1'b0;
      output_valid = 1'b1; cmd = CMD_STREAM;
      for (int i = 0; i < 6; i++) begin
         activation_outputs = mk(8'(8'h30 + i), 8'(8'h40 + i));
         tick();
         check("ovf flag", 32'(overflow), (i >= 4) ? 1 : 0);
      end
      output_valid = 1'b0;
      check("ovf busy drain", 32'(busy), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("ovf drain data", 32'(out_data), 32'({8'(8'h40 + i), 8'(8'h30 + i)}));
         check("ovf drain idx", 32'(out_row_idx), 32'(i));
         check("ovf drain last", 32'(out_last), 0);
         tick();
      end
      check("ovf done", 32'(done), 1);
      check("ovf sticky", 32'(overflow), 1);
      tick();
      start = 1'b1; num_rows = 5'd1;
      tick();
      start = 1'b0;
      check("ovf cleared by start", 32'(overflow), 0);
      output_valid = 1'b1; activation_outputs = mk(8'h77, 8'h88);
      tick();
      output_valid = 1'b0;
      check("single row last", 32'(out_last), 1);
      check("single row data", 32'(out_data), 32'h8877);
      tick();
      check("single row done", 32'(done), 1);
      tick();

      // Command filtering and mid-job start
      out_ready = 1'b0;
      start = 1'b1; num_rows = 5'd2;
      tick();
      start = 1'b0;
      output_valid = 1'b1; cmd = CMD_WRITE_WEIGHTS; activation_outputs = mk(8'hAA, 8'hBB);
      tick();
      check("filter write_weights", 32'(out_valid), 0);
      cmd = CMD_NONE;
      start = 1'b1; num_rows = 5'd5;
      tick();
      start = 1'b0;
      check("filter none", 32'(out_valid), 0);
      cmd = CMD_STREAM; activation_outputs = mk(8'h01, 8'h02);
      tick();
      activation_outputs = mk(8'h03, 8'h04);
      tick();
      output_valid = 1'b0;
      out_ready = 1'b1;
      check("filter idx0", 32'(out_row_idx), 0);
      check("filter data0", 32'(out_data), 32'h0201);
      check("filter last0", 32'(out_last), 0);
      tick();
      check("filter idx1", 32'(out_row_idx), 1);
      check("filter last1", 32'(out_last), 1);
      tick();
      check("filter done", 32'(done), 1);
      tick();

      // Zero-row start
      start = 1'b1; num_rows = 5'd0;
      tick();
      start = 1'b0;
      check("zero done", 32'(done), 1);
      check("zero valid", 32'(out_valid), 0);
      check("zero busy", 32'(busy), 0);
      tick();
      check("zero done one cycle", 32'(done), 0);

      // Asynchronous reset with two rows buffered
      out_ready = 1'b0;
      start = 1'b1; num_rows = 5'd3;
      tick();
      start = 1'b0;
      output_valid = 1'b1; cmd = CMD_STREAM; activation_outputs = mk(8'h55, 8'h66);
      tick(); tick();
      output_valid = 1'b0;
      check("arst pre valid", 32'(out_valid), 1);
      #2;
      resetn = 1'b0;
      #1;
      check_all_zero("arst");
      #6;
      resetn = 1'b1;
      tick(); tick();
      check("arst post valid", 32'(out_valid), 0);
      check("arst post busy", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gemm_output_collector.md
# gemm_output_collector

Receive-side companion to the GEMM systolic array driver. Captures activation output rows streamed by GEMM (`output_valid` while `cmd == CMD_STREAM`) into a small row FIFO. Re-presents them to a downstream consumer over a valid/ready interface, tagged with row index and last-row flag. Tracks a job of `num_rows` expected rows, raises `stall_req` toward the driver when buffer space runs low, and reports completion and overflow.

## Interface
- `SA_SIZE`, default 2: columns per output row.
- `WEIGHT_ACTIVATION_SIZE`, default 8: bits per element.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥2.
- `MAX_ROWS`, default 16: largest job size.

Ports:
- `clk`  in  1: clock.
- `resetn`  in  1: asynchronous reset, active-low.
- `start`  in  1: one-cycle job start pulse.
- `num_rows`  in  $clog2(MAX_ROWS+1): rows expected in the job. Sampled on `start`.
- `cmd`  in  command_t (GEMM_pkg): current GEMM command.
- `output_valid`  in  1: GEMM row valid.
- `activation_outputs`  in  [WEIGHT_ACTIVATION_SIZE-1:0] x SA_SIZE: GEMM output row.
- `out_valid`  out  1: row available downstream.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  [WEIGHT_ACTIVATION_SIZE-1:0] x SA_SIZE: row payload.
- `out_row_idx`  out  $clog2(MAX_ROWS): index of the row within the job.
- `out_last`  out  1: row is the job's final row.
- `stall_req`  out  1: request that the driver pause streaming.
- `busy`  out  1: job in progress.
- `done`  out  1: one-cycle completion pulse.
- `overflow`  out  1: sticky; a row was dropped in this job.

## Operation
- **FSM states:** IDLE, COLLECT, DRAIN, DONE.
- **IDLE**
  - `start` with `num_rows != 0`: latch `num_rows`, clear `captured`, clear `overflow`, go to COLLECT.
  - `start` with `num_rows == 0`: go directly to DONE.
  - GEMM rows are ignored.
- **Capture condition:** state COLLECT, `output_valid == 1` and `cmd == CMD_STREAM`.
  - On each capture, push {row, `captured`, `captured == num_rows-1`} and increment `captured`.
  - Rows arriving with any other `cmd` (CMD_NONE, CMD_WRITE_WEIGHTS) are ignored and do not abort the job.
- **COLLECT → DRAIN:** when the final row is captured (`captured` reaches `num_rows`).
- **DRAIN → DONE:** on the edge where the FIFO becomes empty, i.e. the pop of the `out_last` entry.
- **DONE:** lasts one cycle, then returns to IDLE.
- **Output signals:**
  - `done` = (state == DONE).
  - `busy` = (state ∈ {COLLECT, DRAIN}).
  - `start` while `busy` is ignored.
- **FIFO:** DEPTH entries, each holding payload, row index and last flag.
  - Pop occurs when `out_valid && out_ready`.
  - `out_*` are driven from the head entry and are stable while `out_valid && !out_ready`.
- **Full FIFO:**
  - A capture without a same-cycle pop drops the row, sets `overflow`, and still increments `captured`, so the job terminates.
  - If the dropped row was the last, the previously stored tail entry is not marked last. DRAIN still exits when the FIFO is empty.
  - Capture with a simultaneous pop while full is accepted, with no overflow.
- **Wrap-around:** pointers are $clog2(DEPTH)+1 bits with natural wrap. Full/empty is decided from the MSB comparison.
- **stall_req:** combinational, = (fifo_count ≥ DEPTH-1) while busy, 0 otherwise.
- **Data path:** no arithmetic on row data; values pass through bit-exact.

## Timing
- **Reset values:** `resetn` low asynchronously forces IDLE, empties the FIFO and clears all counters.
  - `out_valid`=0, `out_data`=0, `out_row_idx`=0, `out_last`=0, `stall_req`=0, `busy`=0, `done`=0, `overflow`=0.
  - Reset mid-job discards all buffered rows.
- **Capture latency:** a row captured at edge N into an empty FIFO gives `out_valid`=1 in cycle N+1.
- **Throughput:** one push and one pop per cycle sustained.
- **busy:** rises the cycle after `start`.
- **done:** high exactly one cycle, the cycle after the last pop. `busy` is 0 in that cycle.
- **stall_req:** reflects the post-edge count, so the driver sees it one cycle before a further push could fill the FIFO.

## Test plan
- **Basic job:**
  - Stimulus: `num_rows`=2, rows {3,2} then {5,6} on consecutive cycles with CMD_STREAM, `out_ready`=1.
  - Response: outputs {3,2} idx0 last0, then {5,6} idx1 last1. `done` 1 cycle after the second pop. `overflow`=0.
- **Backpressure:**
  - Stimulus: `num_rows`=4, `out_ready`=0, four rows streamed.
  - Response: `stall_req`=1 once 3 rows are held. Rows 0-3 are all stored and `out_data` is stable. Raising `out_ready` drains them in order and `done` pulses.
- **Overflow:**
  - Stimulus: `num_rows`=6, `out_ready`=0, six rows streamed.
  - Response: rows 4 and 5 dropped and `overflow`=1. Drain yields idx0-3 with `out_last`=0 on all; `done` still pulses. The next `start` clears `overflow`.
- **Command filtering:**
  - Stimulus: `output_valid`=1 with `cmd`=CMD_WRITE_WEIGHTS and with `cmd`=CMD_NONE, mid-job.
  - Response: no capture, `captured` unchanged.
- **Zero and busy start:**
  - Stimulus: `start` with `num_rows`=0; separately, `start` during COLLECT.
  - Response: `done` pulses next cycle with no `out_valid`; the mid-job `start` is ignored.
- **Async reset mid-job:**
  - Stimulus: pull `resetn` low with 2 rows buffered.
  - Response: all outputs are 0 immediately without a clock edge. After reset, `out_valid` stays 0.
